// File: rtl/router_out_fifo.sv
// router_out_fifo: per-destination output FIFO of the 1x3 router with packet-boundary tracking.
// Define ROUTER_FIFO_TIMEOUT_EN to build the idle-timeout auto-flush.

module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             soft_rst,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] dout,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             timeout_flush
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH:0]   rd_entry_s;
  logic             wr_acc_s, rd_acc_s, tmo_fire_s, flush_s;

  assign empty      = (occ_q == {(AW+1){1'b0}});
  assign full       = (occ_q == FULL_L);
  assign valid_out  = !empty;
  assign dout       = dout_q;
  // A full FIFO drops the write even when a read frees a slot in the same cycle.
  assign wr_acc_s   = write_enb && !full;
  assign rd_acc_s   = read_enb && !empty;
  assign flush_s    = soft_rst || tmo_fire_s;
  assign rd_entry_s = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy, read data and packet counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    pkt_cnt_d = pkt_cnt_q;
    dout_d    = dout_q;
    if (flush_s) begin
      wr_ptr_d  = {AW{1'b0}};
      rd_ptr_d  = {AW{1'b0}};
      occ_d     = {(AW+1){1'b0}};
      pkt_cnt_d = 7'd0;
      dout_d    = {WIDTH{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = rd_entry_s[WIDTH-1:0];
        // Header byte carries payload length in [7:2]; +1 accounts for the parity byte.
        if (rd_entry_s[WIDTH]) begin
          pkt_cnt_d = {1'b0, rd_entry_s[7:2]} + 7'd1;
        end else if (pkt_cnt_q != 7'd0) begin
          pkt_cnt_d = pkt_cnt_q - 7'd1;
        end else begin
          pkt_cnt_d = 7'd0;
        end
      end else begin
        rd_ptr_d  = rd_ptr_q;
        dout_d    = dout_q;
        pkt_cnt_d = pkt_cnt_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      occ_q     <= {(AW+1){1'b0}};
      pkt_cnt_q <= 7'd0;
      dout_q    <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      pkt_cnt_q <= pkt_cnt_d;
      dout_q    <= dout_d;
    end
  end

  // Storage array; the header flag rides in the top bit of each entry.
  always_ff @(posedge clk) begin
    if (rstn && !flush_s && wr_acc_s) begin
      mem_q[wr_ptr_q] <= {lfd_state, data_in};
    end
  end

`ifdef ROUTER_FIFO_TIMEOUT_EN
  localparam logic [4:0] TMO_L = 5'(TIMEOUT);
  logic [4:0] tmo_q, tmo_d;
  logic       tflush_q, tflush_d;

  assign tmo_fire_s    = (tmo_q == TMO_L);
  assign timeout_flush = tflush_q;

  // Idle counter: soft_rst keeps it, the emptied FIFO then clears it.
  always_comb begin
    tmo_d    = tmo_q;
    tflush_d = 1'b0;
    if (soft_rst) begin
      tmo_d    = tmo_q;
      tflush_d = 1'b0;
    end else if (tmo_fire_s) begin
      tmo_d    = 5'd0;
      tflush_d = 1'b1;
    end else if (rd_acc_s || empty) begin
      tmo_d = 5'd0;
    end else if (valid_out && !read_enb) begin
      tmo_d = tmo_q + 5'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Timeout registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q    <= 5'd0;
      tflush_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      tflush_q <= tflush_d;
    end
  end
`else
  assign tmo_fire_s    = 1'b0;
  assign timeout_flush = 1'b0;
`endif

  router_out_fifo_chk #(.TIMEOUT(TIMEOUT)) u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .soft_rst     (soft_rst),
    .pkt_cnt_i    (pkt_cnt_q),
    .timeout_flush(timeout_flush)
  );
endmodule

// Property checker for the packet counter and the timeout pulse.
module router_out_fifo_chk #(
  parameter int TIMEOUT = 30
) (
  input logic       clk,
  input logic       rstn,
  input logic       soft_rst,
  input logic [6:0] pkt_cnt_i,
  input logic       timeout_flush
);
  localparam bit TMO_OK = (TIMEOUT > 0) && (TIMEOUT < 32);

  a_tmo_range: assert property (@(posedge clk) TMO_OK);
  a_flush_clears_pkt: assert property (@(posedge clk) (!rstn || soft_rst) |=> (pkt_cnt_i == 7'd0));
  a_pkt_range: assert property (@(posedge clk) disable iff (!rstn) pkt_cnt_i <= 7'd64);
  a_tmo_pulse: assert property (@(posedge clk) disable iff (!rstn) timeout_flush |=> !timeout_flush);
endmodule

// File: tb/tb_router_out_fifo.sv
// Self-checking bench for router_out_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.

module tb_router_out_fifo;
  localparam int TIMEOUT = 30;
  localparam int DEPTH   = 16;

  logic       clk = 1'b0;
  logic       rstn, soft_rst, write_enb, lfd_state, read_enb;
  logic [7:0] data_in, dout;
  logic       valid_out, full, empty, timeout_flush;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] mdl_q[$];
  logic [7:0] mdl_dout   = 8'h00;
  logic       mdl_tflush = 1'b0;
  int         mdl_tmo    = 0;

  logic [7:0] pkt_bytes [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h1E};

  router_out_fifo #(.DEPTH(DEPTH), .WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .soft_rst     (soft_rst),
    .write_enb    (write_enb),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .read_enb     (read_enb),
    .dout         (dout),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .timeout_flush(timeout_flush)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge, from the current input values.
  task automatic mdl_edge();
    logic       was_empty, do_rd, do_wr;
    logic [8:0] ent;
    if (!rstn) begin
      mdl_q.delete(); mdl_dout = 8'h00; mdl_tmo = 0; mdl_tflush = 1'b0;
    end else if (soft_rst) begin
      mdl_q.delete(); mdl_dout = 8'h00; mdl_tflush = 1'b0;
`ifdef ROUTER_FIFO_TIMEOUT_EN
    end else if (mdl_tmo == TIMEOUT) begin
      mdl_q.delete(); mdl_dout = 8'h00; mdl_tflush = 1'b1; mdl_tmo = 0;
`endif
    end else begin
      was_empty  = (mdl_q.size() == 0);
      do_rd      = read_enb && !was_empty;
      do_wr      = write_enb && (mdl_q.size() < DEPTH);
      mdl_tflush = 1'b0;
      if (do_rd) begin
        ent = mdl_q.pop_front();
        mdl_dout = ent[7:0];
      end
      if (do_wr) mdl_q.push_back({lfd_state, data_in});
      if (do_rd || was_empty) mdl_tmo = 0;
      else if (!read_enb) mdl_tmo++;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic we, input logic lfd,
                     input logic [7:0] d, input logic re);
    rstn = r; soft_rst = s; write_enb = we; lfd_state = lfd; data_in = d; read_enb = re;
    @(posedge clk);
    mdl_edge();
    #1;
    check_eq("dout", dout, mdl_dout);
    check_eq("empty", empty, mdl_q.size() == 0);
    check_eq("valid_out", valid_out, mdl_q.size() != 0);
    check_eq("full", full, mdl_q.size() == DEPTH);
    check_eq("timeout_flush", timeout_flush, mdl_tflush);
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    cyc(1'b1, 1'b0, 1'b1, lfd, d, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; soft_rst = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = 8'h00; read_enb = 1'b0;

    // Reset with writes presented
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1'b0);
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_valid", valid_out, 1'b0);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_tflush", timeout_flush, 1'b0);
    idle();
    check_eq("rst_nowrite", empty, 1'b1);

    // One packet in order
    for (int i = 0; i < 5; i++) wr(pkt_bytes[i], i == 0);
    check_eq("pkt_valid", valid_out, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rd();
      check_eq("pkt_dout", dout, pkt_bytes[i]);
    end
    check_eq("pkt_empty", empty, 1'b1);

    // Fill, drop on full, drain, then wrap
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    check_eq("fill_full", full, 1'b1);
    wr(8'hAA, 1'b0);
    check_eq("drop_full", full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd();
      check_eq("drain_dout", dout, 8'(i));
    end
    check_eq("drain_empty", empty, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i), i > 0);
      if (i > 0) check_eq("wrap_dout", dout, 8'(8'h40 + i - 1));
    end
    rd();
    check_eq("wrap_last", dout, 8'h53);
    check_eq("wrap_empty", empty, 1'b1);

    // Simultaneous read+write at full: write dropped
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i), 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b1);
    check_eq("sim_full_dout", dout, 8'h80);
    check_eq("sim_full_notfull", full, 1'b0);
    for (int i = 1; i < 16; i++) begin
      rd();
      check_eq("sim_full_drain", dout, 8'(8'h80 + i));
    end
    check_eq("sim_full_empty", empty, 1'b1);

    // Simultaneous at occupancy 8: both accepted
    for (int i = 0; i < 8; i++) wr(8'(8'h90 + i), 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1);
    check_eq("sim_half_dout", dout, 8'h90);
    for (int i = 1; i < 8; i++) begin
      rd();
      check_eq("sim_half_drain", dout, 8'(8'h90 + i));
    end
    rd();
    check_eq("sim_half_new", dout, 8'hF0);
    check_eq("sim_half_empty", empty, 1'b1);

    // Soft reset mid-packet
    wr(8'h0C, 1'b1); wr(8'h11, 1'b0); wr(8'h22, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
    check_eq("srst_empty", empty, 1'b1);
    check_eq("srst_dout", dout, 8'h00);
    idle();
    check_eq("srst_nostore", empty, 1'b1);

`ifdef ROUTER_FIFO_TIMEOUT_EN
    // Timeout fires after the idle budget
    wr(8'h5A, 1'b0);
    for (int k = 0; k < 30; k++) begin
      idle();
      check_eq("tmo_early", timeout_flush, 1'b0);
    end
    idle();
    check_eq("tmo_fire", timeout_flush, 1'b1);
    check_eq("tmo_empty", empty, 1'b1);
    idle();
    check_eq("tmo_pulse", timeout_flush, 1'b0);
    // A read before the budget expires restarts the count
    wr(8'h5B, 1'b0); wr(8'h5C, 1'b0);
    for (int k = 0; k < 27; k++) idle();
    rd();
    check_eq("tmo_rd_dout", dout, 8'h5B);
    for (int k = 0; k < 30; k++) begin
      idle();
      check_eq("tmo_prevent", timeout_flush, 1'b0);
    end
    check_eq("tmo_kept", valid_out, 1'b1);
    rd();
    check_eq("tmo_rd2", dout, 8'h5C);
`else
    // Without the timeout feature a stalled byte stays put
    wr(8'h5A, 1'b0);
    for (int k = 0; k < 40; k++) begin
      idle();
      check_eq("notmo_flush", timeout_flush, 1'b0);
    end
    check_eq("notmo_kept", valid_out, 1'b1);
    rd();
    check_eq("notmo_dout", dout, 8'h5A);
`endif

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int n = 0; n < 800; n++) begin
      int   wprob;
      logic r, s, we, re, lfd;
      wprob = ((n / 100) % 2 == 0) ? 75 : 25;
      r   = ($urandom_range(0, 199) != 0);
      s   = ($urandom_range(0, 63) == 0);
      we  = ($urandom_range(0, 99) < wprob);
      re  = ($urandom_range(0, 99) < (100 - wprob));
      lfd = ($urandom_range(0, 5) == 0);
      cyc(r, s, we, lfd, 8'($urandom), re);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
